// File: rtl/propagate_literal_seq_pkg.sv
// Shared types and sizing for the sequential literal-propagation engine.
// Literals are {variable index, polarity}; variable index 0 is the empty slot.
package propagate_literal_seq_pkg;

  localparam int VAR_W       = 3;
  localparam int MAX_LITS    = 5;
  localparam int MAX_CLAUSES = 10;

  localparam int LCNT_W = $clog2(MAX_LITS + 1);
  localparam int CCNT_W = $clog2(MAX_CLAUSES + 1);

  typedef struct packed {
    logic [VAR_W-1:0] var_id;
    logic             pol;
  } lit_t;

  typedef struct packed {
    lit_t [0:MAX_LITS-1] lits;
    logic [LCNT_W-1:0]   count;
  } clause_t;

  typedef struct packed {
    clause_t [0:MAX_CLAUSES-1] clauses;
    logic [CCNT_W-1:0]         count;
  } formula_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam lit_t zero_lit = '0;

endpackage

// File: rtl/propagate_literal_seq_clause_reduce.sv
// Combinational reduction of one clause against the assigned literal:
// detects satisfaction, strips falsified literals and compacts survivors to slot 0.
module clause_reduce
  import propagate_literal_seq_pkg::*;
#(
  parameter int VAR_W    = propagate_literal_seq_pkg::VAR_W,
  parameter int MAX_LITS = propagate_literal_seq_pkg::MAX_LITS
) (
  input  clause_t           i_clause,
  input  lit_t              i_lit,
  output logic              o_satisfied,
  output clause_t           o_clause,
  output logic [LCNT_W-1:0] o_count
);

  logic [MAX_LITS-1:0] w_keep;
  logic [MAX_LITS-1:0] w_hit;
  logic [LCNT_W-1:0]   w_cnt;
  logic                w_lit_live;

  assign w_cnt      = (i_clause.count > LCNT_W'(MAX_LITS)) ? LCNT_W'(MAX_LITS) : i_clause.count;
  assign w_lit_live = (i_lit.var_id != {VAR_W{1'b0}});

  // A variable-0 assigned literal neither satisfies nor falsifies anything.
  generate
    for (genvar gi = 0; gi < MAX_LITS; gi++) begin : g_slot
      logic w_active;
      logic w_opposite;
      assign w_active    = (LCNT_W'(gi) < w_cnt);
      assign w_opposite  = w_lit_live && (i_clause.lits[gi].var_id == i_lit.var_id)
                           && (i_clause.lits[gi].pol != i_lit.pol);
      assign w_hit[gi]   = w_active && w_lit_live && (i_clause.lits[gi] == i_lit);
      assign w_keep[gi]  = w_active && !w_opposite;
    end
  endgenerate

  always_comb begin
    logic [LCNT_W-1:0] pos;
    o_clause = '0;
    pos      = '0;
    for (int s = 0; s < MAX_LITS; s++) begin
      if (w_keep[s]) begin
        o_clause.lits[pos] = i_clause.lits[s];
        pos                = pos + LCNT_W'(1);
      end
    end
    o_clause.count = pos;
  end

  assign o_satisfied = |w_hit;
  assign o_count     = o_clause.count;

endmodule

// File: rtl/propagate_literal_seq.sv
// Sequential propagation engine: latches a literal and formula, scans one clause per
// cycle, aborts on the first empty clause and records the first unit clause.
module propagate_literal_seq
  import propagate_literal_seq_pkg::*;
#(
  parameter int VAR_W       = propagate_literal_seq_pkg::VAR_W,
  parameter int MAX_LITS    = propagate_literal_seq_pkg::MAX_LITS,
  parameter int MAX_CLAUSES = propagate_literal_seq_pkg::MAX_CLAUSES
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     find,
  input  lit_t     in_lit,
  input  formula_t in_formula,
  output logic     busy,
  output logic     ended,
  output logic     empty_clause,
  output logic     empty_formula,
  output logic     unit_found,
  output lit_t     unit_lit,
  output formula_t out_formula
);

  state_t            r_state;
  state_t            w_state_next;
  lit_t              r_lit;
  formula_t          r_formula;
  logic [CCNT_W-1:0] r_rptr;
  logic [CCNT_W-1:0] r_wptr;
  formula_t          r_out_formula;
  logic              r_empty_clause;
  logic              r_empty_formula;
  logic              r_unit_found;
  lit_t              r_unit_lit;

  formula_t          w_in_clamped;
  logic              w_sat;
  clause_t           w_red;
  logic [LCNT_W-1:0] w_red_cnt;
  logic              w_none;
  logic              w_conflict;
  logic              w_last;

  always_comb begin
    w_in_clamped = in_formula;
    if (in_formula.count > CCNT_W'(MAX_CLAUSES)) begin
      w_in_clamped.count = CCNT_W'(MAX_CLAUSES);
    end
  end

  clause_reduce #(
    .VAR_W    (VAR_W),
    .MAX_LITS (MAX_LITS)
  ) u_reduce (
    .i_clause    (r_formula.clauses[r_rptr]),
    .i_lit       (r_lit),
    .o_satisfied (w_sat),
    .o_clause    (w_red),
    .o_count     (w_red_cnt)
  );

  assign w_none     = (r_formula.count == '0);
  assign w_conflict = !w_sat && (w_red_cnt == '0);
  assign w_last     = (r_rptr == r_formula.count - CCNT_W'(1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (find) w_state_next = ST_SCAN;
      ST_SCAN: if (w_none || w_conflict || w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    ended = 1'b0;
    case (r_state)
      ST_SCAN: busy  = 1'b1;
      ST_DONE: ended = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_lit           <= zero_lit;
      r_formula       <= '0;
      r_rptr          <= '0;
      r_wptr          <= '0;
      r_out_formula   <= '0;
      r_empty_clause  <= 1'b0;
      r_empty_formula <= 1'b0;
      r_unit_found    <= 1'b0;
      r_unit_lit      <= zero_lit;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (find) begin
            r_lit           <= in_lit;
            r_formula       <= w_in_clamped;
            r_rptr          <= '0;
            r_wptr          <= '0;
            r_out_formula   <= '0;
            r_empty_clause  <= 1'b0;
            r_empty_formula <= 1'b0;
            r_unit_found    <= 1'b0;
            r_unit_lit      <= zero_lit;
          end
        end
        ST_SCAN: begin
          if (w_none) begin
            r_empty_formula <= 1'b1;
          end else begin
            r_rptr <= r_rptr + CCNT_W'(1);
            if (w_conflict) begin
              r_empty_clause <= 1'b1;
            end else if (!w_sat) begin
              r_out_formula.clauses[r_wptr] <= w_red;
              r_out_formula.count           <= r_wptr + CCNT_W'(1);
              r_wptr                        <= r_wptr + CCNT_W'(1);
              if ((w_red_cnt == LCNT_W'(1)) && !r_unit_found) begin
                r_unit_found <= 1'b1;
                r_unit_lit   <= w_red.lits[0];
              end
            end
            // Nothing survives only if nothing was written before and this clause drops.
            if (w_last && !w_conflict) begin
              r_empty_formula <= (r_wptr == '0) && w_sat;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign empty_clause  = r_empty_clause;
  assign empty_formula = r_empty_formula;
  assign unit_found    = r_unit_found;
  assign unit_lit      = r_unit_lit;
  assign out_formula   = r_out_formula;

endmodule

// File: tb/tb_propagate_literal_seq.sv
// Self-checking bench: scenario tasks compare the engine against a queue-based
// propagation model of the formula semantics.
module tb_propagate_literal_seq;
  import propagate_literal_seq_pkg::*;

  logic     clock = 1'b0;
  logic     reset;
  logic     find;
  lit_t     in_lit;
  formula_t in_formula;
  logic     busy, ended, empty_clause, empty_formula, unit_found;
  lit_t     unit_lit;
  formula_t out_formula;

  int n_pass  = 0;
  int n_total = 0;

  int obs_lat;
  bit obs_busy;
  bit obs_single;

  formula_t exp_f;
  bit       exp_ec, exp_ef, exp_uf;
  lit_t     exp_ul;
  int       exp_lat;

  always #5 clock = ~clock;

  propagate_literal_seq dut (
    .clock         (clock),
    .reset         (reset),
    .find          (find),
    .in_lit        (in_lit),
    .in_formula    (in_formula),
    .busy          (busy),
    .ended         (ended),
    .empty_clause  (empty_clause),
    .empty_formula (empty_formula),
    .unit_found    (unit_found),
    .unit_lit      (unit_lit),
    .out_formula   (out_formula)
  );

  function automatic lit_t mk_lit(input int v);
    lit_t r;
    r.var_id = VAR_W'((v < 0) ? -v : v);
    r.pol    = (v > 0);
    return r;
  endfunction

  function automatic clause_t mk(input int n, input int a = 0, input int b = 0,
                                 input int c = 0, input int d = 0, input int e = 0);
    clause_t r;
    r         = '0;
    r.lits[0] = mk_lit(a);
    r.lits[1] = mk_lit(b);
    r.lits[2] = mk_lit(c);
    r.lits[3] = mk_lit(d);
    r.lits[4] = mk_lit(e);
    r.count   = LCNT_W'(n);
    return r;
  endfunction

  function automatic formula_t spec_formula();
    formula_t f;
    f            = '0;
    f.count      = CCNT_W'(10);
    f.clauses[0] = mk(5, 1, 2, 3, 4, 5);
    f.clauses[1] = mk(2, -2, -5);
    f.clauses[2] = mk(3, -1, -2, -5);
    f.clauses[3] = mk(2, 1, 2);
    f.clauses[4] = mk(1, 1);
    f.clauses[5] = mk(1, 2);
    f.clauses[6] = mk(1, 3);
    f.clauses[7] = mk(1, 4);
    f.clauses[8] = mk(3, -2, -3, 4);
    f.clauses[9] = mk(2, -3, 2);
    return f;
  endfunction

  function automatic formula_t rand_formula();
    formula_t f;
    f.count = CCNT_W'($urandom_range(0, 12));
    for (int i = 0; i < MAX_CLAUSES; i++) begin
      f.clauses[i].count = ($urandom_range(0, 19) == 0) ? '0 : LCNT_W'($urandom_range(1, 7));
      for (int s = 0; s < MAX_LITS; s++) begin
        f.clauses[i].lits[s].var_id = VAR_W'($urandom_range(0, 7));
        f.clauses[i].lits[s].pol    = 1'($urandom_range(0, 1));
      end
    end
    return f;
  endfunction

  // Reference: walk the active literals of each clause as a list.
  function automatic void model(input lit_t l, input formula_t f);
    int   n, m, w;
    bit   sat;
    lit_t q[$];
    exp_f  = '0;
    exp_ec = 1'b0;
    exp_uf = 1'b0;
    exp_ul = '0;
    w      = 0;
    n      = (int'(f.count) > MAX_CLAUSES) ? MAX_CLAUSES : int'(f.count);
    exp_lat = (n == 0) ? 1 : n;
    for (int i = 0; i < n; i++) begin
      m   = (int'(f.clauses[i].count) > MAX_LITS) ? MAX_LITS : int'(f.clauses[i].count);
      sat = 1'b0;
      q.delete();
      for (int s = 0; s < m; s++) begin
        if (l.var_id == 0) q.push_back(f.clauses[i].lits[s]);
        else if (f.clauses[i].lits[s] == l) sat = 1'b1;
        else if (f.clauses[i].lits[s].var_id != l.var_id) q.push_back(f.clauses[i].lits[s]);
      end
      if (sat) continue;
      if (q.size() == 0) begin
        exp_ec  = 1'b1;
        exp_lat = i + 1;
        break;
      end
      foreach (q[s]) exp_f.clauses[w].lits[s] = q[s];
      exp_f.clauses[w].count = LCNT_W'(q.size());
      if (q.size() == 1 && !exp_uf) begin
        exp_uf = 1'b1;
        exp_ul = q[0];
      end
      w++;
    end
    exp_f.count = CCNT_W'(w);
    exp_ef      = (w == 0) && !exp_ec;
  endfunction

  // Drives one request and records latency / busy / pulse width; find is re-raised
  // with junk inputs at cycle 'inject' (0 = never).
  task automatic do_op(input lit_t l, input formula_t f, input int inject);
    int c;
    @(negedge clock);
    in_lit     = l;
    in_formula = f;
    find       = 1'b1;
    @(posedge clock);
    #1;
    find       = 1'b0;
    in_lit     = mk_lit(-7);
    in_formula = rand_formula();
    obs_busy   = busy;
    obs_lat    = -1;
    c          = 0;
    while (c < 40) begin
      @(posedge clock);
      c++;
      #1;
      find = (c == inject);
      if (find) in_formula = rand_formula();
      if (ended) begin
        obs_lat = c;
        break;
      end
    end
    find = 1'b0;
    @(posedge clock);
    #1;
    obs_single = !ended;
    $display("op lit=%0d/%0d n=%0d lat=%0d out_count=%0d ec=%0b ef=%0b uf=%0b",
             l.var_id, l.pol, f.count, obs_lat, out_formula.count, empty_clause,
             empty_formula, unit_found);
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    find       = 1'b0;
    in_lit     = mk_lit(1);
    in_formula = spec_formula();
    @(posedge clock);
    #1;
    find = 1'b1;
    @(posedge clock);
    #1;
    find = 1'b0;
    n_total++; if (ended !== 1'b0) $display("FAIL rst_ended: got %0b want 0", ended); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy); else n_pass++;
    n_total++; if ({empty_clause, empty_formula, unit_found} !== 3'b000)
      $display("FAIL rst_flags: got %b want 000", {empty_clause, empty_formula, unit_found}); else n_pass++;
    n_total++; if (unit_lit !== zero_lit) $display("FAIL rst_unit_lit: got %h want 0", unit_lit); else n_pass++;
    n_total++; if (out_formula !== '0) $display("FAIL rst_out: got %h want 0", out_formula); else n_pass++;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    n_total++; if ({busy, ended} !== 2'b00) $display("FAIL rst_release: got %b want 00", {busy, ended}); else n_pass++;
  endtask

  task automatic test_spec_positive();
    model(mk_lit(1), spec_formula());
    do_op(mk_lit(1), spec_formula(), 0);
    n_total++; if (obs_lat !== 10) $display("FAIL pos_latency: got %0d want 10", obs_lat); else n_pass++;
    n_total++; if (out_formula.count !== CCNT_W'(7)) $display("FAIL pos_count: got %0d want 7", out_formula.count); else n_pass++;
    n_total++; if (out_formula !== exp_f) $display("FAIL pos_formula: got %h want %h", out_formula, exp_f); else n_pass++;
    n_total++; if (unit_found !== 1'b1 || unit_lit !== mk_lit(2))
      $display("FAIL pos_unit: got %0b/%h want 1/%h", unit_found, unit_lit, mk_lit(2)); else n_pass++;
    n_total++; if ({empty_clause, empty_formula} !== 2'b00) $display("FAIL pos_empty: got %b want 00", {empty_clause, empty_formula}); else n_pass++;
    n_total++; if (!obs_busy || !obs_single) $display("FAIL pos_handshake: got busy=%0b single=%0b want 1 1", obs_busy, obs_single); else n_pass++;
  endtask

  task automatic test_conflict();
    model(mk_lit(-1), spec_formula());
    do_op(mk_lit(-1), spec_formula(), 0);
    n_total++; if (obs_lat !== 5) $display("FAIL conf_latency: got %0d want 5", obs_lat); else n_pass++;
    n_total++; if (empty_clause !== 1'b1 || empty_formula !== 1'b0)
      $display("FAIL conf_flags: got ec=%0b ef=%0b want 1 0", empty_clause, empty_formula); else n_pass++;
    n_total++; if (out_formula.count !== CCNT_W'(3)) $display("FAIL conf_count: got %0d want 3", out_formula.count); else n_pass++;
    n_total++; if (out_formula !== exp_f) $display("FAIL conf_formula: got %h want %h", out_formula, exp_f); else n_pass++;
    n_total++; if (unit_lit !== mk_lit(2)) $display("FAIL conf_unit_lit: got %h want %h", unit_lit, mk_lit(2)); else n_pass++;
  endtask

  task automatic test_all_satisfied();
    formula_t f;
    f            = '0;
    f.count      = CCNT_W'(4);
    f.clauses[0] = mk(1, 1);
    f.clauses[1] = mk(2, 1, 2);
    f.clauses[2] = mk(2, -3, 1);
    f.clauses[3] = mk(3, 4, 5, 1);
    do_op(mk_lit(1), f, 0);
    n_total++; if (obs_lat !== 4) $display("FAIL sat_latency: got %0d want 4", obs_lat); else n_pass++;
    n_total++; if (empty_formula !== 1'b1 || empty_clause !== 1'b0)
      $display("FAIL sat_flags: got ef=%0b ec=%0b want 1 0", empty_formula, empty_clause); else n_pass++;
    n_total++; if (out_formula !== '0) $display("FAIL sat_out: got %h want 0", out_formula); else n_pass++;
  endtask

  task automatic test_zero_var_and_count();
    formula_t f;
    model(mk_lit(0), spec_formula());
    do_op(mk_lit(0), spec_formula(), 0);
    n_total++; if (obs_lat !== 10 || out_formula.count !== CCNT_W'(10))
      $display("FAIL zvar_pass: got lat=%0d count=%0d want 10 10", obs_lat, out_formula.count); else n_pass++;
    n_total++; if (out_formula !== exp_f) $display("FAIL zvar_formula: got %h want %h", out_formula, exp_f); else n_pass++;
    n_total++; if (unit_lit !== mk_lit(1)) $display("FAIL zvar_unit: got %h want %h", unit_lit, mk_lit(1)); else n_pass++;
    f       = spec_formula();
    f.count = '0;
    do_op(mk_lit(2), f, 0);
    n_total++; if (obs_lat !== 1 || !obs_busy) $display("FAIL zcnt_timing: got lat=%0d busy=%0b want 1 1", obs_lat, obs_busy); else n_pass++;
    n_total++; if (empty_formula !== 1'b1 || out_formula !== '0)
      $display("FAIL zcnt_result: got ef=%0b out=%h want 1 0", empty_formula, out_formula); else n_pass++;
  endtask

  task automatic test_clamp();
    formula_t f;
    f       = rand_formula();
    f.count = CCNT_W'(15);
    for (int i = 0; i < MAX_CLAUSES; i++) begin
      f.clauses[i].count = LCNT_W'((i == 0) ? 7 : $urandom_range(1, 7));
      for (int s = 0; s < MAX_LITS; s++) f.clauses[i].lits[s].var_id = VAR_W'($urandom_range(1, 6));
    end
    model(mk_lit(7), f);
    do_op(mk_lit(7), f, 0);
    n_total++; if (obs_lat !== 10 || out_formula.count !== CCNT_W'(10))
      $display("FAIL clamp_clauses: got lat=%0d count=%0d want 10 10", obs_lat, out_formula.count); else n_pass++;
    n_total++; if (out_formula.clauses[0].count !== LCNT_W'(5))
      $display("FAIL clamp_lits: got %0d want 5", out_formula.clauses[0].count); else n_pass++;
    n_total++; if (out_formula !== exp_f) $display("FAIL clamp_formula: got %h want %h", out_formula, exp_f); else n_pass++;
  endtask

  task automatic test_random();
    formula_t f;
    lit_t     l;
    for (int t = 0; t < 40; t++) begin
      f        = rand_formula();
      l.var_id = VAR_W'($urandom_range(0, 7));
      l.pol    = 1'($urandom_range(0, 1));
      model(l, f);
      do_op(l, f, 0);
      n_total++; if (obs_lat !== exp_lat) $display("FAIL rnd%0d_latency: got %0d want %0d", t, obs_lat, exp_lat); else n_pass++;
      n_total++; if (out_formula !== exp_f) $display("FAIL rnd%0d_formula: got %h want %h", t, out_formula, exp_f); else n_pass++;
      n_total++; if ({empty_clause, empty_formula, unit_found} !== {exp_ec, exp_ef, exp_uf})
        $display("FAIL rnd%0d_flags: got %b want %b", t, {empty_clause, empty_formula, unit_found}, {exp_ec, exp_ef, exp_uf}); else n_pass++;
      n_total++; if (unit_lit !== exp_ul) $display("FAIL rnd%0d_unit_lit: got %h want %h", t, unit_lit, exp_ul); else n_pass++;
      n_total++; if (!obs_busy || !obs_single)
        $display("FAIL rnd%0d_handshake: got busy=%0b single=%0b want 1 1", t, obs_busy, obs_single); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    model(mk_lit(1), spec_formula());
    do_op(mk_lit(1), spec_formula(), 2);
    n_total++; if (obs_lat !== 10) $display("FAIL b2b_first_latency: got %0d want 10", obs_lat); else n_pass++;
    n_total++; if (out_formula !== exp_f) $display("FAIL b2b_first_formula: got %h want %h", out_formula, exp_f); else n_pass++;
    model(mk_lit(-1), spec_formula());
    do_op(mk_lit(-1), spec_formula(), 0);
    n_total++; if (obs_lat !== 5) $display("FAIL b2b_second_latency: got %0d want 5", obs_lat); else n_pass++;
    n_total++; if (out_formula !== exp_f || empty_clause !== 1'b1)
      $display("FAIL b2b_second_result: got %h/%0b want %h/1", out_formula, empty_clause, exp_f); else n_pass++;
  endtask

  task automatic test_mid_reset();
    int seen;
    @(negedge clock);
    in_lit     = mk_lit(1);
    in_formula = spec_formula();
    find       = 1'b1;
    @(posedge clock);
    #1;
    find = 1'b0;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    @(posedge clock);
    #1;
    n_total++; if ({busy, ended} !== 2'b00) $display("FAIL midrst_state: got %b want 00", {busy, ended}); else n_pass++;
    n_total++; if (out_formula !== '0 || {empty_clause, empty_formula, unit_found} !== 3'b000 || unit_lit !== zero_lit)
      $display("FAIL midrst_outputs: got %h flags=%b want 0", out_formula, {empty_clause, empty_formula, unit_found}); else n_pass++;
    reset = 1'b1;
    seen  = 0;
    repeat (15) begin
      @(posedge clock);
      #1;
      if (ended || busy) seen++;
    end
    n_total++; if (seen !== 0) $display("FAIL midrst_no_ended: got %0d active cycles want 0", seen); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_spec_positive();
    test_conflict();
    test_all_satisfied();
    test_zero_var_and_count();
    test_clamp();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
